// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU operation sequencer.
//   alu_op_t    - ALU opcodes known to the control unit (others pass through)
//   FLAG_*      - bit positions inside the architectural NZC flag register
//   seq_state_t - sequencer FSM states
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1
  } alu_op_t;

  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/nzc_flag_reg.sv
// nzc_flag_reg: 3-bit architectural flag register, loaded when load=1.
//   clk, rst_n - clock and asynchronous active-low clear
//   load       - capture d on this edge
//   d          - new flag value {N,Z,C}
//   q          - current flag value
module nzc_flag_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [2:0] d,
  output logic [2:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      q <= 3'b000;
    else if (load)
      q <= d;
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: initiator side of the combinational ALU interface.
//   Accepts one op on req_* (valid/ready), registers operands onto alu_*,
//   waits SETTLE_CYCLES, captures result/flags onto resp_* (valid/ready),
//   optionally updates flags_nzc and counts completed responses in op_count.
//   req_*   - request handshake and operands
//   alu_*   - to/from the combinational ALU
//   resp_*  - response handshake and captured result/flags
//   flags_nzc, busy, op_count - status
//
//   state | meaning
//   IDLE  | ready for a request
//   ISSUE | operands on the ALU, settle counter running
//   RESP  | response held until resp_ready
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int SEL_W         = 4,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [SEL_W-1:0] req_sel,
  input  logic             req_setflags,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_negative,
  input  logic             alu_cout,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_zero,
  output logic             resp_negative,
  output logic             resp_cout,
  output logic [2:0]       flags_nzc,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  // Keep the counter at least one bit wide so SETTLE_CYCLES=1 still elaborates.
  localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SC_W-1:0] SC_LOAD = SC_W'(SETTLE_CYCLES - 1);

  seq_state_t      state, state_nxt;
  logic [SC_W-1:0] settle_cnt;
  logic            flag_en;
  logic            accept, capture, done;
  logic [2:0]      flag_d;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (settle_cnt == '0) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      flag_en    <= 1'b0;
      settle_cnt <= '0;
    end else if (accept) begin
      alu_a      <= req_a;
      alu_b      <= req_b;
      alu_sel    <= req_sel;
      flag_en    <= req_setflags;
      settle_cnt <= SC_LOAD;
    end else if (state == ISSUE && settle_cnt != '0) begin
      settle_cnt <= settle_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_result   <= '0;
      resp_zero     <= 1'b0;
      resp_negative <= 1'b0;
      resp_cout     <= 1'b0;
    end else if (capture) begin
      resp_result   <= alu_result;
      resp_zero     <= alu_zero;
      resp_negative <= alu_negative;
      resp_cout     <= alu_cout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      op_count <= '0;
    else if (done)
      op_count <= op_count + 1'b1;
  end

  always_comb begin
    flag_d         = 3'b000;
    flag_d[FLAG_N] = alu_negative;
    flag_d[FLAG_Z] = alu_zero;
    flag_d[FLAG_C] = alu_cout;
  end

  nzc_flag_reg u_flags (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (capture && flag_en),
    .d     (flag_d),
    .q     (flags_nzc)
  );

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  resp_ready = 2'b00;
  logic [31:0] req_a = '0, req_b = '0;
  logic [3:0]  req_sel = '0;
  logic        req_setflags = 1'b0;

  // index 0: SETTLE_CYCLES=1, CNT_W=2; index 1: SETTLE_CYCLES=3, CNT_W=16
  logic [1:0]  req_ready_w, resp_valid_w, busy_w;
  logic [1:0]  resp_zero_w, resp_neg_w, resp_cout_w;
  logic [1:0]  alu_zero_w, alu_neg_w, alu_cout_w;
  logic [31:0] alu_a_w [2];
  logic [31:0] alu_b_w [2];
  logic [3:0]  alu_sel_w [2];
  logic [31:0] alu_res_w [2];
  logic [31:0] resp_res_w [2];
  logic [2:0]  flags_w [2];
  logic [15:0] cnt_w [2];
  logic [1:0]  s1_cnt;
  logic [15:0] s3_cnt;

  int checks = 0;
  int errors = 0;
  int settle_of [2] = '{1, 3};
  logic [15:0] cnt_mask [2] = '{16'h0003, 16'hffff};
  logic [2:0]  exp_flags [2] = '{3'b000, 3'b000};
  logic [15:0] exp_cnt [2] = '{16'h0, 16'h0};

  always #5 clk = ~clk;

  // Reference ALU: returns {N, Z, C, result}
  function automatic logic [34:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] sel);
    logic [32:0] s;
    logic [31:0] r;
    logic        c;
    s = '0;
    c = 1'b0;
    case (sel)
      4'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32]; end
      4'd1: begin s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; c = s[32]; end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      default: r = ~a;
    endcase
    return {r[31], (r == 32'd0), c, r};
  endfunction

  assign {alu_neg_w[0], alu_zero_w[0], alu_cout_w[0], alu_res_w[0]} = alu_ref(alu_a_w[0], alu_b_w[0], alu_sel_w[0]);
  assign {alu_neg_w[1], alu_zero_w[1], alu_cout_w[1], alu_res_w[1]} = alu_ref(alu_a_w[1], alu_b_w[1], alu_sel_w[1]);
  assign cnt_w[0] = {14'd0, s1_cnt};
  assign cnt_w[1] = s3_cnt;

  alu_op_sequencer #(.WIDTH(32), .SEL_W(4), .SETTLE_CYCLES(1), .CNT_W(2)) u_s1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready_w[0]),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel), .req_setflags(req_setflags),
    .alu_a(alu_a_w[0]), .alu_b(alu_b_w[0]), .alu_sel(alu_sel_w[0]),
    .alu_result(alu_res_w[0]), .alu_zero(alu_zero_w[0]), .alu_negative(alu_neg_w[0]),
    .alu_cout(alu_cout_w[0]),
    .resp_valid(resp_valid_w[0]), .resp_ready(resp_ready[0]),
    .resp_result(resp_res_w[0]), .resp_zero(resp_zero_w[0]), .resp_negative(resp_neg_w[0]),
    .resp_cout(resp_cout_w[0]),
    .flags_nzc(flags_w[0]), .busy(busy_w[0]), .op_count(s1_cnt)
  );

  alu_op_sequencer #(.WIDTH(32), .SEL_W(4), .SETTLE_CYCLES(3), .CNT_W(16)) u_s3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready_w[1]),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel), .req_setflags(req_setflags),
    .alu_a(alu_a_w[1]), .alu_b(alu_b_w[1]), .alu_sel(alu_sel_w[1]),
    .alu_result(alu_res_w[1]), .alu_zero(alu_zero_w[1]), .alu_negative(alu_neg_w[1]),
    .alu_cout(alu_cout_w[1]),
    .resp_valid(resp_valid_w[1]), .resp_ready(resp_ready[1]),
    .resp_result(resp_res_w[1]), .resp_zero(resp_zero_w[1]), .resp_negative(resp_neg_w[1]),
    .resp_cout(resp_cout_w[1]),
    .flags_nzc(flags_w[1]), .busy(busy_w[1]), .op_count(s3_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_idle_reset(input int w);
    chk($sformatf("rst_alu_a[%0d]", w), alu_a_w[w], 0);
    chk($sformatf("rst_resp_valid[%0d]", w), resp_valid_w[w], 0);
    chk($sformatf("rst_resp_result[%0d]", w), resp_res_w[w], 0);
    chk($sformatf("rst_flags[%0d]", w), flags_w[w], 0);
    chk($sformatf("rst_op_count[%0d]", w), cnt_w[w], 0);
    chk($sformatf("rst_busy[%0d]", w), busy_w[w], 0);
  endtask

  // One op through instance w, response held back for `hold` cycles.
  task automatic do_op(input int w, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] sel, input logic sf, input int hold);
    logic [34:0] e;
    int n;
    e = alu_ref(a, b, sel);
    @(negedge clk);
    req_a = a; req_b = b; req_sel = sel; req_setflags = sf;
    req_valid[w] = 1'b1;
    chk($sformatf("req_ready_idle[%0d]", w), req_ready_w[w], 1);
    @(posedge clk); #1;
    req_valid[w] = 1'b0;
    chk($sformatf("busy_accept[%0d]", w), busy_w[w], 1);
    n = 0;
    while (!resp_valid_w[w] && n < 20) begin
      chk($sformatf("alu_a_issue[%0d]", w), alu_a_w[w], a);
      chk($sformatf("alu_b_issue[%0d]", w), alu_b_w[w], b);
      chk($sformatf("alu_sel_issue[%0d]", w), alu_sel_w[w], sel);
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("latency[%0d]", w), n, settle_of[w]);
    if (sf) exp_flags[w] = e[34:32];
    chk($sformatf("resp_result[%0d]", w), resp_res_w[w], e[31:0]);
    chk($sformatf("resp_cout[%0d]", w), resp_cout_w[w], e[32]);
    chk($sformatf("resp_zero[%0d]", w), resp_zero_w[w], e[33]);
    chk($sformatf("resp_neg[%0d]", w), resp_neg_w[w], e[34]);
    chk($sformatf("flags[%0d]", w), flags_w[w], exp_flags[w]);
    chk($sformatf("op_count_resp[%0d]", w), cnt_w[w], exp_cnt[w]);
    if (hold > 0) begin
      req_valid[w] = 1'b1;
      req_a = ~a; req_b = ~b; req_sel = sel + 4'd1;
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk($sformatf("hold_valid[%0d]", w), resp_valid_w[w], 1);
      chk($sformatf("hold_result[%0d]", w), resp_res_w[w], e[31:0]);
      chk($sformatf("hold_flags_out[%0d]", w), {resp_neg_w[w], resp_zero_w[w], resp_cout_w[w]}, e[34:32]);
      chk($sformatf("hold_req_ready[%0d]", w), req_ready_w[w], 0);
      chk($sformatf("hold_op_count[%0d]", w), cnt_w[w], exp_cnt[w]);
      chk($sformatf("hold_alu_a[%0d]", w), alu_a_w[w], a);
    end
    @(negedge clk);
    req_valid[w] = 1'b0;
    resp_ready[w] = 1'b1;
    chk($sformatf("hs_req_ready[%0d]", w), req_ready_w[w], 0);
    @(posedge clk); #1;
    resp_ready[w] = 1'b0;
    exp_cnt[w] = (exp_cnt[w] + 16'd1) & cnt_mask[w];
    chk($sformatf("post_resp_valid[%0d]", w), resp_valid_w[w], 0);
    chk($sformatf("post_req_ready[%0d]", w), req_ready_w[w], 1);
    chk($sformatf("post_op_count[%0d]", w), cnt_w[w], exp_cnt[w]);
    chk($sformatf("post_alu_a_kept[%0d]", w), alu_a_w[w], a);
    chk($sformatf("post_flags[%0d]", w), flags_w[w], exp_flags[w]);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [35:0] q[$];
    logic [35:0] item;
    int accepts, done_n, last_acc;

    #12;
    chk_idle_reset(0);
    chk_idle_reset(1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("req_ready_after_rst0", req_ready_w[0], 1);
    chk("req_ready_after_rst1", req_ready_w[1], 1);

    // directed: add, sub to zero, sub without flag update, long response hold
    do_op(0, 32'd14, 32'd5, 4'd0, 1'b1, 0);
    chk("t1_result", resp_res_w[0], 32'd19);
    chk("t1_flags", flags_w[0], 3'b000);
    do_op(0, 32'd6, 32'd6, 4'd1, 1'b1, 0);
    chk("t2_flag_z", flags_w[0][1], 1);
    do_op(0, 32'd4, 32'd3, 4'd1, 1'b0, 5);
    chk("t2_flag_z_kept", flags_w[0][1], 1);

    // randomized ops on both instances, including non-ADD/SUB opcodes
    for (int i = 0; i < 10; i++) begin
      ra = $urandom;
      rb = ($urandom_range(3) == 0) ? ra : $urandom;
      do_op(i % 2, ra, rb, 4'($urandom_range(7)), 1'($urandom_range(1)), $urandom_range(3));
    end

    // slow-settle instance, then reset in the middle of ISSUE
    do_op(1, 32'h8000_0000, 32'd1, 4'd1, 1'b1, 1);
    @(negedge clk);
    req_a = 32'h1234_5678; req_b = 32'd9; req_sel = 4'd0; req_setflags = 1'b1;
    req_valid[1] = 1'b1;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk); #3;
    chk("t5_in_issue", busy_w[1], 1);
    rst_n = 1'b0;
    #1;
    exp_flags = '{3'b000, 3'b000};
    exp_cnt = '{16'h0, 16'h0};
    chk_idle_reset(1);
    chk_idle_reset(0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t5_req_ready", req_ready_w[1], 1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("t5_no_stale_resp", resp_valid_w[1], 0);
    end

    // back-to-back with resp_ready high on the 2-bit counter instance
    accepts = 0; done_n = 0; last_acc = -1;
    resp_ready[0] = 1'b1;
    req_valid[0] = 1'b1;
    for (int cyc = 0; cyc < 40 && done_n < 4; cyc++) begin
      @(negedge clk);
      if (resp_valid_w[0]) begin
        item = q.pop_front();
        if (item[35]) exp_flags[0] = item[34:32];
        chk("b2b_result", resp_res_w[0], item[31:0]);
        chk("b2b_flags", flags_w[0], exp_flags[0]);
        chk("b2b_op_count", cnt_w[0], exp_cnt[0]);
        exp_cnt[0] = (exp_cnt[0] + 16'd1) & cnt_mask[0];
        done_n++;
      end
      if (req_ready_w[0]) begin
        if (accepts < 4) begin
          if (accepts > 0) chk("b2b_interval", cyc - last_acc, settle_of[0] + 2);
          last_acc = cyc;
          ra = $urandom; rb = $urandom;
          req_a = ra; req_b = rb; req_sel = 4'($urandom_range(1));
          req_setflags = 1'($urandom_range(1));
          q.push_back({req_setflags, alu_ref(ra, rb, req_sel)});
          accepts++;
        end else begin
          req_valid[0] = 1'b0;
        end
      end
    end
    chk("b2b_done", done_n, 4);
    @(negedge clk);
    req_valid[0] = 1'b0;
    resp_ready[0] = 1'b0;
    chk("b2b_wrap", cnt_w[0], exp_cnt[0]);
    chk("b2b_wrap_zero", cnt_w[0], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
